gost_ctr: RTL and testbench
===========================

GOST_CTR -- requirements
Module: gost_ctr

Interface
REQ-001 SHALL: reset irst, synchronous, active-high; clock iclk.
REQ-002 SHALL: port iclk  in  1  clock, all logic on rising edge.
REQ-003 SHALL: port irst  in  1  synchronous active-high reset.
REQ-004 SHALL: port iinit  in  1  one-cycle pulse; loads the IV and starts a new message.
REQ-005 SHALL: port iiv  in  32  IV, sampled only when iinit=1.
REQ-006 SHALL: port ivalid  in  1  input byte valid.
REQ-007 SHALL: port idata  in  8  plaintext/ciphertext input byte.
REQ-008 SHALL: port oready  out  1  block accepts idata this cycle.
REQ-009 SHALL: port ovalid  out  1  output byte valid.
REQ-010 SHALL: port odata  out  8  XOR-ed output byte.
REQ-011 SHALL: port iready  in  1  downstream accepts odata this cycle.
REQ-012 SHALL: port ogost_start  out  1  one-cycle start pulse to the cipher core, which always encrypts (ienc_dec tied 0 externally).
REQ-013 SHALL: port ogost_block  out  64  counter block driven to cipher core iblock.
REQ-014 SHALL: port igost_block  in  64  cipher core oblock (gamma).
REQ-015 SHALL: port igost_done  in  1  cipher core done level, high when the core is idle.

Function
REQ-016 SHALL: implement CTR mode (GOST R 34.13): initial counter = {iiv, 32'h0}; one 64-bit gamma per 8 bytes; counter +1 mod 2^64 per block (FFFF_FFFF_FFFF_FFFF wraps to 0).
REQ-017 SHALL: drive ogost_block continuously from the 64-bit counter register.
REQ-018 SHALL: use FSM states IDLE, START, SETTLE, WAIT, STREAM.
REQ-019 SHALL: IDLE has oready=0 and ogost_start=0; the FSM leaves IDLE only on iinit.
REQ-020 SHALL: START asserts ogost_start for exactly one cycle, then moves to SETTLE.
REQ-021 SHALL: SETTLE ignores igost_done for one cycle, then moves to WAIT.
REQ-022 SHALL: WAIT moves to STREAM on igost_done=1 and latches igost_block into the gamma register in that same edge; byte index = 0.
REQ-023 SHALL: in STREAM, oready = !ovalid || iready; a transfer happens when ivalid && oready.
REQ-024 SHALL: on a transfer, odata <= idata ^ gamma byte[index], with index 0 = gamma[63:56] and index 7 = gamma[7:0]; set ovalid <= 1; index +1.
REQ-025 SHALL: on the transfer at index 7, set counter +1, index <= 0, and move to START; oready=0 until the next STREAM.
REQ-026 SHALL: clear ovalid when ovalid && iready and no new transfer occurs in that cycle; odata holds its value while ovalid && !iready.
REQ-027 SHALL: when output stalls in states other than STREAM, hold ovalid/odata until iready.
REQ-028 SHALL: give iinit priority over all activity in any state: counter <= {iiv,32'h0}; index <= 0; ovalid <= 0; gamma cleared; state <= START; a partially used gamma is discarded.
REQ-029 SHALL: ignore ivalid when oready=0; idata is never consumed outside STREAM.
REQ-030 SHALL: introduce no combinational path from ivalid to oready.

Reset
REQ-031 SHALL: on irst, set state=IDLE, counter=0, gamma=0, index=0, ovalid=0, odata=0, ogost_start=0, oready=0.
REQ-032 SHALL: give irst priority over iinit in the same cycle.
REQ-033 SHALL: treat irst asserted mid-block the same as reset from power-up; no pending start pulse may be emitted afterwards.

Verification
REQ-034 SHALL: cover init — iinit with iiv=32'h12345678 -> ogost_start pulse 1 cycle later; ogost_block=64'h12345678_00000000.
REQ-035 SHALL: cover a full block with a core model returning 64'h0102030405060708 and idata=8'h00 x8 -> odata = 01,02,...,08 in order, then a second ogost_start with ogost_block=64'h12345678_00000001.
REQ-036 SHALL: cover backpressure — iready held 0 for 5 cycles after the first output -> ovalid=1, odata stable, oready=0, no byte lost or duplicated.
REQ-037 SHALL: cover counter wrap — iiv=32'hFFFFFFFF, lower half preset via 2^32-1 blocks or a forced counter=64'hFFFF_FFFF_FFFF_FFFF -> next ogost_block=64'h0.
REQ-038 SHALL: cover mid-block re-init — iinit after 3 bytes with iiv=32'hA5A5A5A5 -> ovalid=0, new start with 64'hA5A5A5A5_00000000, first new byte uses gamma[63:56].
REQ-039 SHALL: cover reset — irst during WAIT -> all outputs 0 next cycle; igost_done=1 afterwards causes no transition.

Source files
------------

// File: rtl/gost_ctr.sv
// CTR-mode (GOST R 34.13) byte-stream wrapper around an external 64-bit block cipher core.
// One cipher request produces 8 bytes of gamma; the counter advances once per block.
module gost_ctr (
    input  logic        iclk,
    input  logic        irst,
    input  logic        iinit,
    input  logic [31:0] iiv,
    input  logic        ivalid,
    input  logic [7:0]  idata,
    output logic        oready,
    output logic        ovalid,
    output logic [7:0]  odata,
    input  logic        iready,
    output logic        ogost_start,
    output logic [63:0] ogost_block,
    input  logic [63:0] igost_block,
    input  logic        igost_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SETTLE,
        WAIT,
        STREAM
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] counter_q, counter_d;
    logic [63:0] gamma_q, gamma_d;
    logic [2:0]  index_q, index_d;
    logic        ovalid_q, ovalid_d;
    logic [7:0]  odata_q, odata_d;

    logic        ready;
    logic        transfer;
    logic [7:0]  gammaByte;

    // Readiness depends only on registered state and iready, never on ivalid.
    assign ready     = (state_q == STREAM) && (!ovalid_q || iready);
    assign transfer  = ready && ivalid;
    assign gammaByte = gamma_q[{3'd7 - index_q, 3'b000} +: 8];

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        gamma_d   = gamma_q;
        index_d   = index_q;
        ovalid_d  = ovalid_q;
        odata_d   = odata_q;

        if (ovalid_q && iready) begin
            ovalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
            end
            START: begin
                state_d = SETTLE;
            end
            // The core's done level is still high from the previous block here.
            SETTLE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (igost_done) begin
                    state_d = STREAM;
                    gamma_d = igost_block;
                    index_d = 3'd0;
                end
            end
            STREAM: begin
                if (transfer) begin
                    odata_d  = idata ^ gammaByte;
                    ovalid_d = 1'b1;
                    if (index_q == 3'd7) begin
                        index_d   = 3'd0;
                        counter_d = counter_q + 64'd1;
                        state_d   = START;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new message discards any partially used gamma and pending output.
        if (iinit) begin
            counter_d = {iiv, 32'h0};
            index_d   = 3'd0;
            ovalid_d  = 1'b0;
            gamma_d   = 64'h0;
            state_d   = START;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q   <= IDLE;
            counter_q <= 64'h0;
            gamma_q   <= 64'h0;
            index_q   <= 3'd0;
            ovalid_q  <= 1'b0;
            odata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            gamma_q   <= gamma_d;
            index_q   <= index_d;
            ovalid_q  <= ovalid_d;
            odata_q   <= odata_d;
        end
    end

    assign oready      = ready;
    assign ovalid      = ovalid_q;
    assign odata       = odata_q;
    assign ogost_start = (state_q == START);
    assign ogost_block = counter_q;

endmodule

// File: tb/tb_gost_ctr.sv
// Self-checking bench for gost_ctr: a behavioural cipher-core model plus a keystream
// reference built from the counter sequence, driven with randomized traffic.
module tb_gost_ctr;

    logic        iclk = 1'b0;
    logic        irst, iinit, ivalid, iready;
    logic [31:0] iiv;
    logic [7:0]  idata, odata;
    logic        oready, ovalid, ogost_start;
    logic [63:0] ogost_block;
    logic [63:0] igost_block = 64'h0;
    logic        igost_done  = 1'b1;

    int checks = 0;
    int fails  = 0;

    bit          fixedGamma  = 1'b0;
    int          coreLat     = 2;
    int          coreCnt     = 0;
    logic [63:0] coreLatched = 64'h0;

    logic [63:0] mCtr = 64'h0;
    int          mIdx = 0;
    int          acceptCount = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  outLog[$];
    logic [63:0] startLog[$];
    logic [63:0] expStarts[$];

    gost_ctr dut (
        .iclk        (iclk),
        .irst        (irst),
        .iinit       (iinit),
        .iiv         (iiv),
        .ivalid      (ivalid),
        .idata       (idata),
        .oready      (oready),
        .ovalid      (ovalid),
        .odata       (odata),
        .iready      (iready),
        .ogost_start (ogost_start),
        .ogost_block (ogost_block),
        .igost_block (igost_block),
        .igost_done  (igost_done)
    );

    always #5 iclk = ~iclk;

    // Stand-in cipher: any fixed function of the block works, since the wrapper never
    // inspects the gamma beyond XOR-ing it with the data.
    function automatic logic [63:0] gammaFn(input logic [63:0] c);
        if (fixedGamma) return 64'h0102030405060708;
        return (c * 64'h9E3779B97F4A7C15) ^ 64'hC3A55A3C0F1E2D4B;
    endfunction

    function automatic logic [7:0] gammaByte(input logic [63:0] c, input int idx);
        logic [63:0] g;
        g = gammaFn(c);
        return g[(7 - idx) * 8 +: 8];
    endfunction

    // Core: done drops on the start edge, rises with the result after coreLat cycles.
    always @(posedge iclk) begin
        if (irst) begin
            igost_done <= 1'b1;
            coreCnt    <= 0;
        end else if (ogost_start) begin
            igost_done  <= 1'b0;
            coreCnt     <= coreLat;
            coreLatched <= ogost_block;
        end else if (coreCnt > 0) begin
            coreCnt <= coreCnt - 1;
            if (coreCnt == 1) begin
                igost_done  <= 1'b1;
                igost_block <= gammaFn(coreLatched);
            end
        end
    end

    task automatic clearLogs();
        expQ.delete();
        outLog.delete();
        startLog.delete();
        expStarts.delete();
    endtask

    // One cycle of stimulus; records what the DUT does and what the reference expects.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r,
                                 input logic init, input logic [31:0] iv);
        @(negedge iclk);
        ivalid = v;
        idata  = d;
        iready = r;
        iinit  = init;
        iiv    = iv;
        #1;
        if (ogost_start) startLog.push_back(ogost_block);
        if (ovalid && iready) outLog.push_back(odata);
        if (init) begin
            while (expQ.size() > outLog.size()) void'(expQ.pop_back());
            mCtr = {iv, 32'h0};
            mIdx = 0;
            expStarts.push_back(mCtr);
        end else if (ivalid && oready) begin
            expQ.push_back(d ^ gammaByte(mCtr, mIdx));
            acceptCount++;
            mIdx++;
            if (mIdx == 8) begin
                mIdx = 0;
                mCtr = mCtr + 64'd1;
                expStarts.push_back(mCtr);
            end
        end
    endtask

    task automatic streamBytes(input int n, input int pv, input int pr, input bit zero);
        int target;
        int budget;
        logic v, r;
        logic [7:0] d;
        target = acceptCount + n;
        budget = 0;
        while (acceptCount < target && budget < 4000) begin
            v = (int'($urandom_range(99)) < pv);
            r = (int'($urandom_range(99)) < pr);
            d = zero ? 8'h00 : 8'($urandom);
            applyStimulus(v, d, r, 1'b0, 32'h0);
            budget++;
        end
        checks++;
        if (acceptCount < target) begin
            fails++;
            $display("[TB] FAIL stream_timeout: accepted %0d bytes, required %0d", acceptCount, target);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expQ.size() > outLog.size() || startLog.size() < expStarts.size()) && n < 200) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (n >= 200) begin
            fails++;
            $display("[TB] FAIL drain_timeout: outputs %0d of %0d, starts %0d of %0d",
                     outLog.size(), expQ.size(), startLog.size(), expStarts.size());
        end
    endtask

    task automatic test_reset();
        irst = 1'b1; iinit = 1'b0; iiv = 32'h0; ivalid = 1'b0; idata = 8'h00; iready = 1'b0;
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        #1;
        checks++; if (oready !== 1'b0) begin fails++; $display("[TB] FAIL reset_oready: got %b want 0", oready); end
        checks++; if (ovalid !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovalid: got %b want 0", ovalid); end
        checks++; if (odata !== 8'h00) begin fails++; $display("[TB] FAIL reset_odata: got %h want 00", odata); end
        checks++; if (ogost_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_start: got %b want 0", ogost_start); end
        checks++; if (ogost_block !== 64'h0) begin fails++; $display("[TB] FAIL reset_block: got %h want 0", ogost_block); end
        irst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 32'h0);
            checks++; if (oready !== 1'b0) begin fails++; $display("[TB] FAIL idle_oready: got %b want 0", oready); end
            checks++; if (ogost_start !== 1'b0) begin fails++; $display("[TB] FAIL idle_start: got %b want 0", ogost_start); end
        end
    endtask

    task automatic test_init();
        fixedGamma = 1'b0; coreLat = 2;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        checks++; if (ogost_start !== 1'b1) begin fails++; $display("[TB] FAIL init_start: got %b want 1", ogost_start); end
        checks++; if (ogost_block !== 64'h12345678_00000000) begin fails++; $display("[TB] FAIL init_block: got %h want 1234567800000000", ogost_block); end
        checks++; if (ovalid !== 1'b0) begin fails++; $display("[TB] FAIL init_ovalid: got %b want 0", ovalid); end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        checks++; if (ogost_start !== 1'b0) begin fails++; $display("[TB] FAIL init_pulse_width: got %b want 0", ogost_start); end
    endtask

    task automatic test_full_block();
        logic [7:0] got;
        fixedGamma = 1'b1; coreLat = 3;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678);
        streamBytes(8, 100, 100, 1'b1);
        drain();
        checks++; if (outLog.size() != 8) begin fails++; $display("[TB] FAIL block_count: got %0d want 8", outLog.size()); end
        for (int i = 0; i < 8; i++) begin
            got = (i < outLog.size()) ? outLog[i] : 8'hxx;
            checks++;
            if (got !== 8'(i + 1)) begin fails++; $display("[TB] FAIL block_byte%0d: got %h want %h", i, got, 8'(i + 1)); end
        end
        checks++;
        if (startLog.size() < 2 || startLog[1] !== 64'h12345678_00000001) begin
            fails++;
            $display("[TB] FAIL block_second_start: got %0d starts, want second block 1234567800000001", startLog.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold;
        logic [7:0] got;
        fixedGamma = 1'b0; coreLat = 2;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h0BADF00D);
        streamBytes(1, 100, 100, 1'b0);
        hold = 8'hxx;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 32'h0);
            if (k == 0) begin
                hold = odata;
                checks++; if (odata !== expQ[0]) begin fails++; $display("[TB] FAIL bp_first: got %h want %h", odata, expQ[0]); end
            end else begin
                checks++; if (odata !== hold) begin fails++; $display("[TB] FAIL bp_stable: got %h want %h", odata, hold); end
            end
            checks++; if (ovalid !== 1'b1) begin fails++; $display("[TB] FAIL bp_ovalid: got %b want 1", ovalid); end
            checks++; if (oready !== 1'b0) begin fails++; $display("[TB] FAIL bp_oready: got %b want 0", oready); end
        end
        streamBytes(15, 80, 60, 1'b0);
        drain();
        checks++; if (outLog.size() != expQ.size()) begin fails++; $display("[TB] FAIL bp_count: got %0d want %0d", outLog.size(), expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < outLog.size()) ? outLog[i] : 8'hxx;
            checks++; if (got !== expQ[i]) begin fails++; $display("[TB] FAIL bp_byte%0d: got %h want %h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  got;
        logic [63:0] gotBlk;
        fixedGamma = 1'b0; coreLat = 1;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, $urandom);
        streamBytes(40, 70, 70, 1'b0);
        drain();
        checks++; if (outLog.size() != expQ.size()) begin fails++; $display("[TB] FAIL b2b_count: got %0d want %0d", outLog.size(), expQ.size()); end
        for (int i = 0; i < expQ.size(); i++) begin
            got = (i < outLog.size()) ? outLog[i] : 8'hxx;
            checks++; if (got !== expQ[i]) begin fails++; $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, got, expQ[i]); end
        end
        checks++; if (startLog.size() != expStarts.size()) begin fails++; $display("[TB] FAIL b2b_starts: got %0d want %0d", startLog.size(), expStarts.size()); end
        for (int i = 0; i < expStarts.size(); i++) begin
            gotBlk = (i < startLog.size()) ? startLog[i] : 64'hx;
            checks++; if (gotBlk !== expStarts[i]) begin fails++; $display("[TB] FAIL b2b_block%0d: got %h want %h", i, gotBlk, expStarts[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  got;
        logic [63:0] gotBlk;
        fixedGamma = 1'b0; coreLat = 1;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'hFFFFFFFF);
        @(negedge iclk);
        iinit = 1'b0; ivalid = 1'b0; iready = 1'b1;
        force dut.counter_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        mCtr = 64'hFFFF_FFFF_FFFF_FFFF;
        expStarts.delete();
        checks++; if (ogost_start !== 1'b1) begin fails++; $display("[TB] FAIL wrap_start: got %b want 1", ogost_start); end
        checks++; if (ogost_block !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("[TB] FAIL wrap_preset: got %h want all ones", ogost_block); end
        @(posedge iclk);
        #1;
        release dut.counter_q;
        streamBytes(8, 100, 100, 1'b0);
        drain();
        gotBlk = (startLog.size() > 0) ? startLog[0] : 64'hx;
        checks++; if (gotBlk !== 64'h0) begin fails++; $display("[TB] FAIL wrap_block: got %h want 0", gotBlk); end
        for (int i = 0; i < 8; i++) begin
            got = (i < outLog.size()) ? outLog[i] : 8'hxx;
            checks++; if (got !== expQ[i]) begin fails++; $display("[TB] FAIL wrap_byte%0d: got %h want %h", i, got, expQ[i]); end
        end
    endtask

    task automatic test_reinit();
        logic [63:0] gv;
        logic [7:0]  got;
        int          n0;
        fixedGamma = 1'b0; coreLat = 2;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h12345678);
        streamBytes(3, 100, 100, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'hA5A5A5A5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        checks++; if (ovalid !== 1'b0) begin fails++; $display("[TB] FAIL reinit_ovalid: got %b want 0", ovalid); end
        checks++; if (ogost_start !== 1'b1) begin fails++; $display("[TB] FAIL reinit_start: got %b want 1", ogost_start); end
        checks++; if (ogost_block !== 64'hA5A5A5A5_00000000) begin fails++; $display("[TB] FAIL reinit_block: got %h want a5a5a5a500000000", ogost_block); end
        n0 = outLog.size();
        checks++; if (n0 != expQ.size()) begin fails++; $display("[TB] FAIL reinit_flushed: got %0d bytes want %0d", n0, expQ.size()); end
        streamBytes(1, 100, 100, 1'b1);
        drain();
        gv  = gammaFn(64'hA5A5A5A5_00000000);
        got = (n0 < outLog.size()) ? outLog[n0] : 8'hxx;
        checks++; if (got !== gv[63:56]) begin fails++; $display("[TB] FAIL reinit_first_byte: got %h want %h", got, gv[63:56]); end
    endtask

    task automatic test_reset_in_wait();
        fixedGamma = 1'b0; coreLat = 8;
        clearLogs();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 32'h5555AAAA);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 32'h0);
        @(negedge iclk);
        irst = 1'b1;
        @(posedge iclk);
        #1;
        checks++; if (oready !== 1'b0) begin fails++; $display("[TB] FAIL rstw_oready: got %b want 0", oready); end
        checks++; if (ovalid !== 1'b0) begin fails++; $display("[TB] FAIL rstw_ovalid: got %b want 0", ovalid); end
        checks++; if (odata !== 8'h00) begin fails++; $display("[TB] FAIL rstw_odata: got %h want 00", odata); end
        checks++; if (ogost_start !== 1'b0) begin fails++; $display("[TB] FAIL rstw_start: got %b want 0", ogost_start); end
        checks++; if (ogost_block !== 64'h0) begin fails++; $display("[TB] FAIL rstw_block: got %h want 0", ogost_block); end
        @(negedge iclk);
        irst = 1'b0;
        mCtr = 64'h0; mIdx = 0;
        clearLogs();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 32'h0);
            checks++; if (oready !== 1'b0) begin fails++; $display("[TB] FAIL rstw_idle_oready: got %b want 0", oready); end
            checks++; if (ogost_start !== 1'b0) begin fails++; $display("[TB] FAIL rstw_idle_start: got %b want 0", ogost_start); end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_full_block();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reinit();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
